// File: rtl/commit_checker_pkg.sv
// Shared types and defaults for the retirement-side commit checker.
package commit_checker_pkg;

  // Error causes reported on err_code; lower value wins when several fire together.
  typedef enum logic [3:0] {
    ERR_NONE  = 4'd0,
    ERR_ORDER = 4'd1,
    ERR_PC    = 4'd2,
    ERR_RS1   = 4'd3,
    ERR_RS2   = 4'd4,
    ERR_X0    = 4'd5,
    ERR_ALIGN = 4'd6,
    ERR_MEM   = 4'd7
  } err_code_t;

  // Checker lifecycle; HALTED and ERROR are only left through reset.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  localparam logic [31:0] COMMIT_RESET_PC  = 32'h1eceb000;
  localparam logic [31:0] COMMIT_HALT_INST = 32'h00000063;

  // Bit i of fails is set when check i failed; returns the lowest-numbered cause.
  function automatic err_code_t first_error(input logic [7:1] fails);
    err_code_t code;
    code = ERR_NONE;
    for (int i = 7; i >= 1; i--) begin
      if (fails[i]) code = err_code_t'(4'(i));
    end
    return code;
  endfunction

endpackage

// File: rtl/commit_checker_shadow_regfile.sv
// Architectural shadow register file: 32x32, two combinational reads, one write,
// asynchronous clear, x0 hardwired to zero.
module shadow_regfile
  import commit_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rd1_addr,
  output logic [31:0] rd1_data,
  input  logic [4:0]  rd2_addr,
  output logic [31:0] rd2_data,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [32];

  // Write port; every entry is cleared on reset.
  // NOTE: this array is reset deliberately -- the shadow must match a freshly
  // reset core whose registers read as zero, so it cannot map to plain RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wr_addr != 5'd0) begin
      // NOTE: non-blocking so a same-edge read elsewhere sees the pre-commit value.
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports; x0 forced to zero regardless of storage contents.
  always_comb begin
    rd1_data = (rd1_addr == 5'd0) ? 32'd0 : regs[rd1_addr];
    rd2_data = (rd2_addr == 5'd0) ? 32'd0 : regs[rd2_addr];
  end

endmodule

// File: rtl/commit_checker.sv
// Validates each retired instruction against shadow architectural state
// (order, PC chain, register file) and latches the first violation or halt.
module commit_checker
  import commit_checker_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = COMMIT_RESET_PC,
  parameter logic [31:0] HALT_INST = COMMIT_HALT_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [63:0] order,
  input  logic [31:0] inst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_rdata,
  input  logic [31:0] rs2_rdata,
  input  logic        regf_we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_wdata,
  input  logic [31:0] pc_rdata,
  input  logic [31:0] pc_wdata,
  input  logic [3:0]  mem_rmask,
  input  logic [3:0]  mem_wmask,
  output logic        err,
  output logic [3:0]  err_code,
  output logic [63:0] err_order,
  output logic        halt,
  output logic [63:0] commit_count
);

  state_t      state;
  logic [63:0] exp_ord;
  logic [31:0] exp_pc;
  logic [31:0] rs1_shadow;
  logic [31:0] rs2_shadow;
  logic [7:1]  fails;
  err_code_t   cause;
  logic        accept;
  logic        halting;
  logic        shadow_we;

  shadow_regfile u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd1_addr (rs1_addr),
    .rd1_data (rs1_shadow),
    .rd2_addr (rs2_addr),
    .rd2_data (rs2_shadow),
    .we       (shadow_we),
    .wr_addr  (rd_addr),
    .wr_data  (rd_wdata)
  );

  // All checks evaluated in parallel against the pre-commit shadow state.
  // NOTE: every output of this block is assigned on every path, so no latch forms.
  always_comb begin
    fails[1]  = order != exp_ord;
    fails[2]  = pc_rdata != exp_pc;
    fails[3]  = rs1_rdata != rs1_shadow;
    fails[4]  = rs2_rdata != rs2_shadow;
    fails[5]  = regf_we && rd_addr == 5'd0 && rd_wdata != 32'd0;
    fails[6]  = pc_wdata[1:0] != 2'b00;
    fails[7]  = mem_rmask != 4'd0 && mem_wmask != 4'd0;
    cause     = first_error(fails);
    accept    = valid && state == ST_RUN;
    shadow_we = accept && cause == ERR_NONE && regf_we && rd_addr != 5'd0;
    halting   = inst == HALT_INST && pc_wdata == pc_rdata;
  end

  // Checker FSM with registered outputs and expected-order/PC tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      exp_ord      <= '0;
      exp_pc       <= RESET_PC;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      err_order    <= '0;
      halt         <= 1'b0;
      commit_count <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (cause != ERR_NONE) begin
              state     <= ST_ERROR;
              err       <= 1'b1;
              err_code  <= cause;
              err_order <= order;
            end else begin
              exp_ord      <= exp_ord + 64'd1;
              exp_pc       <= pc_wdata;
              commit_count <= commit_count + 64'd1;
              if (halting) begin
                state <= ST_HALTED;
                halt  <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
